// File: rtl/div_xbit_shift_pkg.sv
// Shared arithmetic definitions for the iterative divider: FSM state encoding and
// two's-complement helpers (also used by the shift-add multiplier).
package div_xbit_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Helpers work on a 64-bit container; callers zero-extend and truncate back to
  // their own width. Low bits of a negation depend only on low bits, so truncation is exact.
  localparam int ARITH_MAX_W = 64;

  function automatic logic [ARITH_MAX_W-1:0] neg(input logic [ARITH_MAX_W-1:0] v);
    return ~v + {{(ARITH_MAX_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [ARITH_MAX_W-1:0] abs_val(input logic [ARITH_MAX_W-1:0] v,
                                                     input logic                   is_neg);
    return is_neg ? neg(v) : v;
  endfunction

endpackage

// File: rtl/div_xbit_shift_if.sv
// Request/result bundle of the iterative divider.
// Handshake: i_start is accepted on a rising edge only while o_busy == 0 (IDLE or DONE);
// operands are sampled on that edge only. o_end pulses for one cycle when o_quo/o_rem/
// o_div_zero become valid; they then hold until the next accepted start replaces them.
interface div_xbit_shift_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_num_a;
  logic [DATA_WIDTH-1:0] i_num_b;
  logic                  o_busy;
  logic                  o_end;
  logic                  o_div_zero;
  logic [DATA_WIDTH-1:0] o_quo;
  logic [DATA_WIDTH-1:0] o_rem;

  modport master (
    output i_start, i_num_a, i_num_b,
    input  o_busy, o_end, o_div_zero, o_quo, o_rem
  );

  modport slave (
    input  i_start, i_num_a, i_num_b,
    output o_busy, o_end, o_div_zero, o_quo, o_rem
  );
endinterface

// File: rtl/div_xbit_shift_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic                  dvd_msb,
  input  logic [DATA_WIDTH-1:0] dvs,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic                  q_bit
);

  // Kept one bit wider than the remainder register so the compare stays exact even if
  // a caller feeds a remainder that already uses its top bit.
  logic [DATA_WIDTH+1:0] rem_shift;
  logic [DATA_WIDTH:0]   rem_sub;

  always_comb begin
    rem_shift = {rem_in, dvd_msb};
    rem_sub   = rem_shift[DATA_WIDTH:0] - {1'b0, dvs};
    q_bit     = (rem_shift >= {2'b00, dvs});
    rem_out   = q_bit ? rem_sub : rem_shift[DATA_WIDTH:0];
  end

endmodule

// File: rtl/div_xbit_shift.sv
// Iterative restoring divider: one quotient bit per clock, DATA_WIDTH steps per divide,
// optional two's-complement truncating mode. DATA_WIDTH must lie in 2..64.
module div_xbit_shift
  import div_xbit_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIGNED     = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  div_xbit_shift_if.slave    bus,
  output div_state_e         o_state
);

  localparam int  W         = DATA_WIDTH;
  localparam int  CW        = (W > 1) ? $clog2(W) : 1;
  localparam bit  IS_SIGNED = (SIGNED != 0);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [W:0]    rem_q;
  logic [W:0]    step_rem;
  logic          step_q;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  quo_acc;
  logic          neg_quo;
  logic          neg_rem;

  logic          busy_r;
  logic          end_r;
  logic          dz_r;
  logic [W-1:0]  quo_r;
  logic [W-1:0]  rem_r;

  logic          accept;
  logic          sign_a;
  logic          sign_b;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic [W-1:0]  quo_mag;
  logic [W-1:0]  rem_mag;
  logic [W-1:0]  quo_fin;
  logic [W-1:0]  rem_fin;

  assign accept = bus.i_start && (state != ST_CALC);
  assign sign_a = IS_SIGNED && bus.i_num_a[W-1];
  assign sign_b = IS_SIGNED && bus.i_num_b[W-1];
  assign mag_a  = W'(abs_val(64'(bus.i_num_a), sign_a));
  assign mag_b  = W'(abs_val(64'(bus.i_num_b), sign_b));

  div_step #(
    .DATA_WIDTH (W)
  ) u_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[W-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Result of the final step, before it is written into quo_acc/rem_q.
  assign quo_mag = {quo_acc[W-2:0], step_q};
  assign rem_mag = step_rem[W-1:0];
  // MIN / -1 lands on a magnitude of 2^(W-1) with a positive sign and wraps back to MIN.
  assign quo_fin = neg_quo ? W'(neg(64'(quo_mag))) : quo_mag;
  assign rem_fin = neg_rem ? W'(neg(64'(rem_mag))) : rem_mag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_acc <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      busy_r  <= 1'b0;
      end_r   <= 1'b0;
      dz_r    <= 1'b0;
      quo_r   <= '0;
      rem_r   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          end_r <= 1'b0;
          state <= ST_IDLE;
          if (accept) begin
            if (bus.i_num_b == '0) begin
              // Divide by zero bypasses iteration entirely and reports on the next cycle.
              state  <= ST_DONE;
              end_r  <= 1'b1;
              busy_r <= 1'b0;
              dz_r   <= 1'b1;
              quo_r  <= '1;
              rem_r  <= bus.i_num_a;
            end else begin
              state   <= ST_CALC;
              busy_r  <= 1'b1;
              dz_r    <= 1'b0;
              dvd_q   <= mag_a;
              dvs_q   <= mag_b;
              rem_q   <= '0;
              quo_acc <= '0;
              cnt     <= '0;
              neg_quo <= sign_a ^ sign_b;
              neg_rem <= sign_a;
            end
          end
        end
        ST_CALC: begin
          rem_q   <= step_rem;
          dvd_q   <= {dvd_q[W-2:0], 1'b0};
          quo_acc <= quo_mag;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            state  <= ST_DONE;
            cnt    <= '0;
            busy_r <= 1'b0;
            end_r  <= 1'b1;
            quo_r  <= quo_fin;
            rem_r  <= rem_fin;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          end_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy     = busy_r;
  assign bus.o_end      = end_r;
  assign bus.o_div_zero = dz_r;
  assign bus.o_quo      = quo_r;
  assign bus.o_rem      = rem_r;
  assign o_state        = state;

endmodule

// File: tb/tb_div_xbit_shift.sv
// Directed bench for div_xbit_shift at DATA_WIDTH=8: one unsigned and one signed
// instance share clock and reset; each scenario task checks its own results inline.
module tb_div_xbit_shift;
  import div_xbit_shift_pkg::*;

  logic       clk;
  logic       rst_n;
  div_state_e state_u;
  div_state_e state_s;

  int n_checks = 0;
  int n_fail   = 0;

  div_xbit_shift_if #(.DATA_WIDTH(8)) if_u ();
  div_xbit_shift_if #(.DATA_WIDTH(8)) if_s ();

  div_xbit_shift #(.DATA_WIDTH(8), .SIGNED(0)) u_dut_u (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if_u.slave),
    .o_state (state_u)
  );

  div_xbit_shift #(.DATA_WIDTH(8), .SIGNED(1)) u_dut_s (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if_s.slave),
    .o_state (state_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 (just after an edge); returns in cycle 1 with the operand ports scrambled.
  task automatic start_u(input logic [7:0] a, input logic [7:0] b);
    if_u.i_start = 1'b1;
    if_u.i_num_a = a;
    if_u.i_num_b = b;
    tick();
    if_u.i_start = 1'b0;
    if_u.i_num_a = 8'($urandom_range(0, 255));
    if_u.i_num_b = 8'($urandom_range(0, 255));
  endtask

  task automatic start_s(input logic [7:0] a, input logic [7:0] b);
    if_s.i_start = 1'b1;
    if_s.i_num_a = a;
    if_s.i_num_b = b;
    tick();
    if_s.i_start = 1'b0;
    if_s.i_num_a = 8'($urandom_range(0, 255));
    if_s.i_num_b = 8'($urandom_range(0, 255));
  endtask

  // Advances until o_end is seen; cyc enters as the current cycle index and leaves as the o_end cycle.
  task automatic wait_end_u(inout int cyc);
    while (!if_u.o_end && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_end_s(inout int cyc);
    while (!if_s.o_end && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    if_u.i_start = 1'b0; if_u.i_num_a = '0; if_u.i_num_b = '0;
    if_s.i_start = 1'b0; if_s.i_num_a = '0; if_s.i_num_b = '0;
    repeat (2) tick();
    n_checks++;
    if ({if_u.o_busy, if_u.o_end, if_u.o_div_zero, if_u.o_quo, if_u.o_rem} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_u: got busy=%b end=%b dz=%b quo=%h rem=%h, want all 0",
               if_u.o_busy, if_u.o_end, if_u.o_div_zero, if_u.o_quo, if_u.o_rem);
    end
    n_checks++;
    if ({if_s.o_busy, if_s.o_end, if_s.o_div_zero, if_s.o_quo, if_s.o_rem} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_s: got busy=%b end=%b dz=%b quo=%h rem=%h, want all 0",
               if_s.o_busy, if_s.o_end, if_s.o_div_zero, if_s.o_quo, if_s.o_rem);
    end
    n_checks++;
    if (state_u !== ST_IDLE || state_s !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d/%0d, want %0d", state_u, state_s, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_basic();
    int cyc;
    int busy_bad = 0;
    start_u(8'd200, 8'd7);
    n_checks++;
    if (state_u !== ST_CALC) begin
      n_fail++;
      $display("FAIL basic_state_c1: got %0d, want %0d", state_u, ST_CALC);
    end
    for (int c = 1; c <= 8; c++) begin
      if (if_u.o_busy !== 1'b1 || if_u.o_end !== 1'b0) busy_bad++;
      if (c < 8) tick();
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL basic_busy_window: %0d of cycles 1..8 not busy=1/end=0, want 0", busy_bad);
    end
    tick();
    cyc = 9;
    n_checks++;
    if (if_u.o_end !== 1'b1 || if_u.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end_c9: got end=%b busy=%b, want end=1 busy=0", if_u.o_end, if_u.o_busy);
    end
    n_checks++;
    if (if_u.o_quo !== 8'd28 || if_u.o_rem !== 8'd4 || if_u.o_div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got quo=%0d rem=%0d dz=%b, want quo=28 rem=4 dz=0",
               if_u.o_quo, if_u.o_rem, if_u.o_div_zero);
    end
    repeat (2) tick();
    n_checks++;
    if (if_u.o_end !== 1'b0 || if_u.o_quo !== 8'd28 || if_u.o_rem !== 8'd4 || state_u !== ST_IDLE) begin
      n_fail++;
      $display("FAIL basic_hold: got end=%b quo=%0d rem=%0d state=%0d, want end=0 quo=28 rem=4 idle",
               if_u.o_end, if_u.o_quo, if_u.o_rem, state_u);
    end
    if (cyc != 9) $display("unexpected cycle bookkeeping %0d", cyc);
  endtask

  task automatic test_div_zero();
    start_u(8'd13, 8'd0);
    n_checks++;
    if (if_u.o_end !== 1'b1 || if_u.o_busy !== 1'b0 || if_u.o_div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_flags_c1: got end=%b busy=%b dz=%b, want 1 0 1",
               if_u.o_end, if_u.o_busy, if_u.o_div_zero);
    end
    n_checks++;
    if (if_u.o_quo !== 8'hFF || if_u.o_rem !== 8'd13) begin
      n_fail++;
      $display("FAIL dz_result: got quo=%h rem=%0d, want quo=ff rem=13", if_u.o_quo, if_u.o_rem);
    end
    tick();
    n_checks++;
    if (if_u.o_end !== 1'b0 || if_u.o_div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_pulse_hold: got end=%b dz=%b, want end=0 dz=1", if_u.o_end, if_u.o_div_zero);
    end
    tick();
  endtask

  task automatic test_signed();
    // Hand-computed truncating results (two's complement hex).
    //   -7/2=-3 r-1 | 7/-2=-3 r1 | -128/-1=-128 r0 | -128/7=-18 r-2 | 100/-7=-14 r2 | 127/-128=0 r127 | -5/0
    logic [7:0] ta [7] = '{8'hF9, 8'h07, 8'h80, 8'h80, 8'h64, 8'h7F, 8'hFB};
    logic [7:0] tb [7] = '{8'h02, 8'hFE, 8'hFF, 8'h07, 8'hF9, 8'h80, 8'h00};
    logic [7:0] tq [7] = '{8'hFD, 8'hFD, 8'h80, 8'hEE, 8'hF2, 8'h00, 8'hFF};
    logic [7:0] tr [7] = '{8'hFF, 8'h01, 8'h00, 8'hFE, 8'h02, 8'h7F, 8'hFB};
    int         tc [7] = '{9, 9, 9, 9, 9, 9, 1};
    logic       tz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      int cyc;
      start_s(ta[i], tb[i]);
      cyc = 1;
      wait_end_s(cyc);
      n_checks++;
      if (cyc != tc[i] || if_s.o_quo !== tq[i] || if_s.o_rem !== tr[i] || if_s.o_div_zero !== tz[i]) begin
        n_fail++;
        $display("FAIL signed_%0d (%h/%h): got cyc=%0d quo=%h rem=%h dz=%b, want cyc=%0d quo=%h rem=%h dz=%b",
                 i, ta[i], tb[i], cyc, if_s.o_quo, if_s.o_rem, if_s.o_div_zero,
                 tc[i], tq[i], tr[i], tz[i]);
      end
      tick();
    end
  endtask

  task automatic test_unsigned_table();
    logic [7:0] ta [4] = '{8'd255, 8'd0, 8'd254, 8'd128};
    logic [7:0] tb [4] = '{8'd1,   8'd5, 8'd255, 8'd128};
    logic [7:0] tq [4] = '{8'd255, 8'd0, 8'd0,   8'd1};
    logic [7:0] tr [4] = '{8'd0,   8'd0, 8'd254, 8'd0};
    for (int i = 0; i < 4; i++) begin
      int cyc;
      start_u(ta[i], tb[i]);
      cyc = 1;
      wait_end_u(cyc);
      n_checks++;
      if (cyc != 9 || if_u.o_quo !== tq[i] || if_u.o_rem !== tr[i] || if_u.o_div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL unsigned_%0d (%0d/%0d): got cyc=%0d quo=%0d rem=%0d dz=%b, want cyc=9 quo=%0d rem=%0d dz=0",
                 i, ta[i], tb[i], cyc, if_u.o_quo, if_u.o_rem, if_u.o_div_zero, tq[i], tr[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_u(8'd100, 8'd10);
    repeat (3) tick();
    // cycle 4: this start must be ignored while busy
    if_u.i_start = 1'b1; if_u.i_num_a = 8'd5; if_u.i_num_b = 8'd1;
    tick();
    if_u.i_start = 1'b0;
    cyc = 5;
    wait_end_u(cyc);
    n_checks++;
    if (cyc != 9 || if_u.o_quo !== 8'd10 || if_u.o_rem !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_first: got cyc=%0d quo=%0d rem=%0d, want cyc=9 quo=10 rem=0",
               cyc, if_u.o_quo, if_u.o_rem);
    end
    // start issued on the o_end cycle
    start_u(8'd255, 8'd255);
    n_checks++;
    if (if_u.o_busy !== 1'b1 || if_u.o_end !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b end=%b, want busy=1 end=0", if_u.o_busy, if_u.o_end);
    end
    cyc = 1;
    wait_end_u(cyc);
    n_checks++;
    if (cyc != 9 || if_u.o_quo !== 8'd1 || if_u.o_rem !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_second: got cyc=%0d quo=%0d rem=%0d, want cyc=9 quo=1 rem=0",
               cyc, if_u.o_quo, if_u.o_rem);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int ends = 0;
    start_u(8'd200, 8'd7);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if_u.o_busy, if_u.o_end, if_u.o_div_zero, if_u.o_quo, if_u.o_rem} !== 19'd0 ||
        state_u !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midreset_async: got busy=%b end=%b dz=%b quo=%h rem=%h state=%0d, want all 0 idle",
               if_u.o_busy, if_u.o_end, if_u.o_div_zero, if_u.o_quo, if_u.o_rem, state_u);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (if_u.o_end === 1'b1 || if_u.o_busy === 1'b1) ends++;
    end
    n_checks++;
    if (ends != 0) begin
      n_fail++;
      $display("FAIL midreset_abandon: got %0d cycles with end/busy after reset, want 0", ends);
    end
    start_u(8'd9, 8'd3);
    cyc = 1;
    wait_end_u(cyc);
    n_checks++;
    if (cyc != 9 || if_u.o_quo !== 8'd3 || if_u.o_rem !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_after: got cyc=%0d quo=%0d rem=%0d, want cyc=9 quo=3 rem=0",
               cyc, if_u.o_quo, if_u.o_rem);
    end
    tick();
  endtask

  task automatic test_sweep();
    int bad_u = 0;
    int bad_s = 0;
    int bad_hold = 0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a, b, eq_u, er_u, eq_s, er_s;
      int sa, sb, cyc, want_cyc;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = 8'h80;
      if ($urandom_range(0, 7) == 0) b = 8'hFF;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (b == 8'd0) begin
        eq_u = 8'hFF; er_u = a; eq_s = 8'hFF; er_s = a; want_cyc = 1;
      end else begin
        eq_u = a / b;       er_u = a % b;
        eq_s = 8'(sa / sb); er_s = 8'(sa % sb);
        want_cyc = 9;
      end
      if_u.i_start = 1'b1; if_u.i_num_a = a; if_u.i_num_b = b;
      if_s.i_start = 1'b1; if_s.i_num_a = a; if_s.i_num_b = b;
      tick();
      if_u.i_start = 1'b0; if_u.i_num_a = 8'($urandom_range(0, 255));
      if_s.i_start = 1'b0; if_s.i_num_a = 8'($urandom_range(0, 255));
      cyc = 1;
      wait_end_u(cyc);
      if (cyc != want_cyc || if_u.o_quo !== eq_u || if_u.o_rem !== er_u) begin
        bad_u++;
        if (bad_u <= 4)
          $display("FAIL sweep_u (%0d/%0d): got cyc=%0d quo=%0d rem=%0d, want cyc=%0d quo=%0d rem=%0d",
                   a, b, cyc, if_u.o_quo, if_u.o_rem, want_cyc, eq_u, er_u);
      end
      if (if_s.o_end !== 1'b1 || if_s.o_quo !== eq_s || if_s.o_rem !== er_s) begin
        bad_s++;
        if (bad_s <= 4)
          $display("FAIL sweep_s (%0d/%0d): got end=%b quo=%0d rem=%0d, want end=1 quo=%0d rem=%0d",
                   sa, sb, if_s.o_end, $signed(if_s.o_quo), $signed(if_s.o_rem),
                   $signed(eq_s), $signed(er_s));
      end
      repeat (1 + $urandom_range(0, 2)) begin
        tick();
        if (if_u.o_end !== 1'b0 || if_s.o_end !== 1'b0 ||
            if_u.o_quo !== eq_u || if_u.o_rem !== er_u ||
            if_s.o_quo !== eq_s || if_s.o_rem !== er_s) bad_hold++;
      end
    end
    n_checks++;
    if (bad_u != 0) begin
      n_fail++;
      $display("FAIL sweep_unsigned: got %0d bad vectors, want 0", bad_u);
    end
    n_checks++;
    if (bad_s != 0) begin
      n_fail++;
      $display("FAIL sweep_signed: got %0d bad vectors, want 0", bad_s);
    end
    n_checks++;
    if (bad_hold != 0) begin
      n_fail++;
      $display("FAIL sweep_pulse_hold: got %0d cycles with long o_end or moving results, want 0", bad_hold);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unsigned_basic();
    test_div_zero();
    test_signed();
    test_unsigned_table();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
